poci_burst_serializer: RTL and testbench
========================================

Name: poci_burst_serializer

Overview:
Parametrised POCI readout engine. Selects a word from a flattened register bank by address and serialises it onto a single line clocked by sclk. Supports multi-word bursts with address auto-increment and wrap, and a selectable bit order. Each word is snapshotted at load time. Sits between the configuration register bank and the POCI pad, replacing the fixed 59-entry mux and free-running 8-bit shifter.

Parameters:
WIDTH, 8, bits per register word
NUM_REGS, 59, number of readable registers; valid addresses 1..NUM_REGS, address 0 reserved
ADDR_W, 8, address width; must satisfy 2**ADDR_W > NUM_REGS
LEN_W, 8, burst length counter width
AUTO_INC, 1, 1 = address increments per burst word; 0 = same address re-read every word

Ports:
sclk  input  1  serial clock; all state changes on rising edge
rstn  input  1  asynchronous, active-low reset
start  input  1  request a burst; sampled on sclk rising edge
start_addr  input  ADDR_W  first address of the burst
burst_len  input  LEN_W  number of words in the burst; 0 = request ignored
msb_first  input  1  bit order; 1 = MSB first, 0 = LSB first; latched at start
reg_bank  input  NUM_REGS*WIDTH  flattened registers; address a (1..NUM_REGS) occupies bits [a*WIDTH-1 : (a-1)*WIDTH]
serial_out  output  1  registered serial data
busy  output  1  burst in progress
word_done  output  1  high during the cycle the last bit of any word is on serial_out
cur_addr  output  ADDR_W  address of the word currently shifting; 0 when idle

Behaviour:
- Reset (rstn low, asynchronous): serial_out=0, busy=0, word_done=0, cur_addr=0, shift register=0, bit counter=0, word counter=0, state=IDLE. Reset mid-burst aborts immediately. No resumption after reset release; a new start is required.
- States: IDLE, SHIFT.
- IDLE, on an edge with start=1 and burst_len!=0:
  - latch cur_addr=start_addr, words_left=burst_len, order=msb_first;
  - load shift register with data(start_addr);
  - serial_out takes the first bit of that word at this same edge (LSB, or MSB if order=1);
  - busy=1, bit counter=0; go to SHIFT.
- IDLE, start=1 with burst_len=0: ignored; all outputs unchanged.
- data(a) = reg_bank word a for 1<=a<=NUM_REGS. For a=0 or a>NUM_REGS, data(a)=0 (never X).
- SHIFT: each edge presents the next bit of the snapshot word.
  - Bit k (k=0..WIDTH-1) is on serial_out during cycle k after the load edge.
  - word_done=1 during the cycle bit WIDTH-1 is presented; 0 otherwise.
  - Latency from start edge to first bit: 0 cycles (first bit visible after the start edge).
- Word boundary: the edge after bit WIDTH-1 is presented, with words_left>1:
  - words_left decrements;
  - if AUTO_INC=1: next address = cur_addr+1, wrapping from NUM_REGS (or any out-of-range value) to 1; address 0 is never generated by increment;
  - if AUTO_INC=0: address held;
  - load data(next address) and present its first bit at the same edge. No gap bits between words.
- Burst end: the edge after the last bit of the last word returns to IDLE with serial_out=0, busy=0, cur_addr=0, word_done=0. busy is high for exactly burst_len*WIDTH cycles.
- start while busy=1: ignored. A start at the terminating edge is also ignored; start is honoured only when the state is IDLE at the edge.
- reg_bank changes during a word do not affect that word; the snapshot is taken at the load edge only. msb_first changes mid-burst are ignored.
- words_left and the bit counter never under- or overflow. WIDTH=1 is legal: word_done is high every busy cycle.

Test Plan:
- Reset: hold rstn=0 with start=1 -> serial_out=0, busy=0, cur_addr=0. Assert rstn=0 mid-word -> all outputs 0 asynchronously, before the next edge.
- Single word, LSB first: reg5=8'hA5, start_addr=5, burst_len=1, msb_first=0 -> serial_out 1,0,1,0,0,1,0,1 over 8 cycles; word_done only on cycle 7; busy for 8 cycles; then idle with serial_out=0.
- MSB first: reg1=8'h3C, msb_first=1 -> serial_out 0,0,1,1,1,1,0,0.
- Burst with wrap: start_addr=58, burst_len=3, AUTO_INC=1 -> cur_addr 58,59,1. 24 contiguous bits with no gap, word_done on cycles 7, 15, 23, busy for 24 cycles.
- Reserved/out-of-range and ignored requests: start_addr=0 -> 8 zero bits with busy=1. start_addr=200 -> 8 zero bits. burst_len=0 -> no busy.
- Snapshot and busy lockout: change reg5 and pulse start with new values mid-word -> shifted word equals the value at the load edge; second start ignored; cur_addr unchanged.

Source files
------------

// File: rtl/poci_burst_serializer.sv
// POCI readout engine: snapshots a register word by address and shifts it out on sclk,
// with multi-word bursts, address auto-increment/wrap and selectable bit order.
module poci_burst_serializer #(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 59,
  parameter int ADDR_W   = 8,
  parameter int LEN_W    = 8,
  parameter bit AUTO_INC = 1'b1
) (
  input  logic                      sclk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         start_addr,
  input  logic [LEN_W-1:0]          burst_len,
  input  logic                      msb_first,
  input  logic [NUM_REGS*WIDTH-1:0] reg_bank,
  output logic                      serial_out,
  output logic                      busy,
  output logic                      word_done,
  output logic [ADDR_W-1:0]         cur_addr
);

  // state | meaning
  // IDLE  | no burst; outputs held at 0, waiting for start with burst_len != 0
  // SHIFT | presenting bits of the snapshot word, one per sclk

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state, state_n;
  logic [WIDTH-1:0]  shreg, shreg_n;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_n, bit_cnt_inc;
  logic [LEN_W-1:0]  words_left, words_left_n;
  logic              order, order_n;
  logic              serial_n, busy_n, word_done_n;
  logic [ADDR_W-1:0] cur_addr_n, next_addr, load_addr;
  logic [WIDTH-1:0]  sel_data;

  assign bit_cnt_inc = bit_cnt + 1'b1;

  always_comb begin
    next_addr = cur_addr;
    if (AUTO_INC) begin
      if (cur_addr == '0 || cur_addr >= ADDR_W'(NUM_REGS))
        next_addr = ADDR_W'(1);
      else
        next_addr = cur_addr + 1'b1;
    end
  end

  assign load_addr = (state == IDLE) ? start_addr : next_addr;

  // Out-of-range and reserved addresses read as zero.
  always_comb begin
    sel_data = '0;
    for (int i = 1; i <= NUM_REGS; i++)
      if (load_addr == ADDR_W'(i))
        sel_data = reg_bank[(i-1)*WIDTH +: WIDTH];
  end

  always_comb begin
    state_n      = state;
    shreg_n      = shreg;
    bit_cnt_n    = bit_cnt;
    words_left_n = words_left;
    order_n      = order;
    serial_n     = serial_out;
    busy_n       = busy;
    word_done_n  = word_done;
    cur_addr_n   = cur_addr;
    unique case (state)
      IDLE: begin
        if (start && burst_len != '0) begin
          state_n      = SHIFT;
          cur_addr_n   = start_addr;
          words_left_n = burst_len;
          order_n      = msb_first;
          serial_n     = msb_first ? sel_data[WIDTH-1] : sel_data[0];
          shreg_n      = msb_first ? (sel_data << 1) : (sel_data >> 1);
          bit_cnt_n    = '0;
          word_done_n  = (WIDTH == 1);
          busy_n       = 1'b1;
        end
      end
      SHIFT: begin
        if (bit_cnt == LAST_BIT) begin
          if (words_left > LEN_W'(1)) begin
            words_left_n = words_left - 1'b1;
            cur_addr_n   = next_addr;
            serial_n     = order ? sel_data[WIDTH-1] : sel_data[0];
            shreg_n      = order ? (sel_data << 1) : (sel_data >> 1);
            bit_cnt_n    = '0;
            word_done_n  = (WIDTH == 1);
          end else begin
            state_n      = IDLE;
            words_left_n = '0;
            shreg_n      = '0;
            bit_cnt_n    = '0;
            serial_n     = 1'b0;
            busy_n       = 1'b0;
            word_done_n  = 1'b0;
            cur_addr_n   = '0;
          end
        end else begin
          bit_cnt_n   = bit_cnt_inc;
          serial_n    = order ? shreg[WIDTH-1] : shreg[0];
          shreg_n     = order ? (shreg << 1) : (shreg >> 1);
          word_done_n = (bit_cnt_inc == LAST_BIT);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      words_left <= '0;
      order      <= 1'b0;
      serial_out <= 1'b0;
      busy       <= 1'b0;
      word_done  <= 1'b0;
      cur_addr   <= '0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      bit_cnt    <= bit_cnt_n;
      words_left <= words_left_n;
      order      <= order_n;
      serial_out <= serial_n;
      busy       <= busy_n;
      word_done  <= word_done_n;
      cur_addr   <= cur_addr_n;
    end
  end

endmodule

// File: tb/tb_poci_burst_serializer.sv
// Directed bench for poci_burst_serializer: expected bits are queued at each start and
// popped one per cycle against serial_out/word_done/busy/cur_addr.
module tb_poci_burst_serializer;

  localparam int WIDTH = 8, NUM_REGS = 59, ADDR_W = 8, LEN_W = 8;

  logic                      sclk = 1'b0;
  logic                      rstn = 1'b0;
  logic                      start = 1'b0;
  logic [ADDR_W-1:0]         start_addr = '0;
  logic [LEN_W-1:0]          burst_len = '0;
  logic                      msb_first = 1'b0;
  logic [NUM_REGS*WIDTH-1:0] reg_bank;
  logic                      serial_out, busy, word_done;
  logic [ADDR_W-1:0]         cur_addr;

  logic [WIDTH-1:0] mem [1:NUM_REGS];

  typedef struct {
    logic             s;
    logic             wd;
    logic [ADDR_W-1:0] addr;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  poci_burst_serializer #(
    .WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .AUTO_INC(1'b1)
  ) dut (
    .sclk(sclk), .rstn(rstn), .start(start), .start_addr(start_addr),
    .burst_len(burst_len), .msb_first(msb_first), .reg_bank(reg_bank),
    .serial_out(serial_out), .busy(busy), .word_done(word_done), .cur_addr(cur_addr)
  );

  always #5 sclk = ~sclk;

  always_comb begin
    for (int i = 1; i <= NUM_REGS; i++)
      reg_bank[(i-1)*WIDTH +: WIDTH] = mem[i];
  end

  function automatic logic [WIDTH-1:0] model_data(input int a);
    if (a >= 1 && a <= NUM_REGS) return mem[a];
    return '0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_burst(input int a, input int len, input bit msb);
    int addr;
    logic [WIDTH-1:0] w;
    exp_t e;
    @(negedge sclk);
    start_addr = ADDR_W'(a);
    burst_len  = LEN_W'(len);
    msb_first  = msb;
    start      = 1'b1;
    addr = a;
    for (int wi = 0; wi < len; wi++) begin
      w = model_data(addr);
      for (int k = 0; k < WIDTH; k++) begin
        e.s    = msb ? w[WIDTH-1-k] : w[k];
        e.wd   = (k == WIDTH-1);
        e.addr = ADDR_W'(addr);
        sb.push_back(e);
      end
      addr = (addr == 0 || addr >= NUM_REGS) ? 1 : addr + 1;
    end
    @(posedge sclk); #1;
    start = 1'b0;
  endtask

  task automatic check_n(input string tag, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      if (sb.size() == 0) begin
        chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk($sformatf("%s_bit%0d", tag, i), 32'(serial_out), 32'(e.s));
        chk($sformatf("%s_wd%0d", tag, i), 32'(word_done), 32'(e.wd));
        chk($sformatf("%s_busy%0d", tag, i), 32'(busy), 32'd1);
        chk($sformatf("%s_addr%0d", tag, i), 32'(cur_addr), 32'(e.addr));
      end
      @(posedge sclk); #1;
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_ser"}, 32'(serial_out), 32'd0);
    chk({tag, "_idle_wd"}, 32'(word_done), 32'd0);
    chk({tag, "_idle_addr"}, 32'(cur_addr), 32'd0);
  endtask

  initial begin
    for (int i = 1; i <= NUM_REGS; i++) mem[i] = WIDTH'($urandom);
    mem[5]  = 8'hA5;
    mem[1]  = 8'h3C;
    mem[58] = 8'hC3;
    mem[59] = 8'h96;

    // Reset held with start asserted
    start = 1'b1; start_addr = 8'd5; burst_len = 8'd1;
    repeat (3) @(posedge sclk);
    #1;
    check_idle("rst_hold");
    @(negedge sclk);
    start = 1'b0;
    rstn  = 1'b1;
    @(posedge sclk); #1;
    check_idle("after_rst");

    // Single word, LSB first
    push_burst(5, 1, 1'b0);
    check_n("lsb_a5", 8);
    check_idle("lsb_a5");

    // Single word, MSB first
    push_burst(1, 1, 1'b1);
    check_n("msb_3c", 8);
    check_idle("msb_3c");

    // Burst wrapping 58, 59, 1
    push_burst(58, 3, 1'b0);
    check_n("wrap", 24);
    check_idle("wrap");

    // Reserved and out-of-range addresses
    push_burst(0, 1, 1'b0);
    check_n("addr0", 8);
    check_idle("addr0");
    push_burst(200, 1, 1'b1);
    check_n("addr200", 8);
    check_idle("addr200");

    // Zero-length request ignored
    push_burst(5, 0, 1'b0);
    check_idle("len0");
    @(posedge sclk); #1;
    check_idle("len0_b");

    // Snapshot and busy lockout; start held through the terminating edge too
    push_burst(5, 1, 1'b0);
    check_n("snap_a", 3);
    mem[5] = 8'h5A; start_addr = 8'd7; burst_len = 8'd2; msb_first = 1'b1; start = 1'b1;
    check_n("snap_b", 5);
    check_idle("snap");
    start = 1'b0;
    @(posedge sclk); #1;
    check_idle("snap_b2");

    // New word after snapshot change, two-word burst with MSB first
    push_burst(5, 2, 1'b1);
    check_n("post_snap", 16);
    check_idle("post_snap");

    // Asynchronous reset mid-word
    push_burst(58, 2, 1'b0);
    check_n("mid_rst", 3);
    #2 rstn = 1'b0;
    #1;
    check_idle("async_rst");
    sb.delete();
    @(negedge sclk);
    rstn = 1'b1;
    @(posedge sclk); #1;
    check_idle("rst_release");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
